// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned STATE_W = 4;

  // Supported instruction opcodes
  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_JMP   = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  // Controller states
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXEC = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  // ALU operation
  localparam logic [1:0] ALU_FUNCT = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Datapath control bundle
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       branch;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  // True for opcodes the controller knows how to execute
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_JMP, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational state-to-control decoder for the multicycle controller.
module mips_mc_outdec
  import mips_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   is_rtype,
  output ctrl_t  ctrl_c
);

  // Per-state control values; anything not set stays 0
  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALU_ADD;
        ctrl_c.pc_src    = PC_ALU;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b = SRCB_BOFF;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
      end
      S_RTEXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = ALU_FUNCT;
      end
      S_ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALU_ADD;
      end
      S_ALUWB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = is_rtype;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = ALU_SUB;
        ctrl_c.pc_src    = PC_BRANCH;
        ctrl_c.branch    = 1'b1;
      end
      S_JUMP: begin
        ctrl_c.pc_src   = PC_JUMP;
        ctrl_c.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute and drives datapath controls.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   Instruction,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegDst,
  output logic              MemToReg,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic              PCEn,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ALUOp,
  output logic [1:0]        PCSrc,
  output logic              illegal_op,
  output logic [STATE_W-1:0] state_o
);

  state_e            state;
  state_e            state_nx;
  logic [OP_W-1:0]   opcode_q;
  logic              illegal_q;
  ctrl_t             ctrl_c;
  ctrl_t             ctrl_g;

  // State, latched opcode and illegal-opcode flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nx;
      illegal_q <= (state == S_DECODE) && !is_legal_op(Instruction);
      if (state == S_DECODE) opcode_q <= Instruction;
    end
  end

  // Next-state; only DECODE looks at the live Instruction bus
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (Instruction)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_RTEXEC;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_BEQ:       state_nx = S_BRANCH;
          OP_JMP:       state_nx = S_JUMP;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEMADR: state_nx = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
      S_MEMWB:  state_nx = S_FETCH;
      S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
      S_RTEXEC: state_nx = S_ALUWB;
      S_ADDIEX: state_nx = S_ALUWB;
      S_ALUWB:  state_nx = S_FETCH;
      S_BRANCH: state_nx = S_FETCH;
      S_JUMP:   state_nx = S_FETCH;
      default:  state_nx = S_FETCH;
    endcase
  end

  mips_mc_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .is_rtype  (opcode_q == OP_RTYPE),
    .ctrl_c    (ctrl_c)
  );

  // Hold every control low while reset is asserted so no access or write escapes
  always_comb begin
    ctrl_g = '0;
    if (rst) ctrl_g = ctrl_c;
  end

  assign PCWrite    = ctrl_g.pc_write;
  assign IorD       = ctrl_g.iord;
  assign MemRead    = ctrl_g.mem_read;
  assign MemWrite   = ctrl_g.mem_write;
  assign IRWrite    = ctrl_g.ir_write;
  assign RegDst     = ctrl_g.reg_dst;
  assign MemToReg   = ctrl_g.mem_to_reg;
  assign RegWrite   = ctrl_g.reg_write;
  assign ALUSrcA    = ctrl_g.alu_src_a;
  assign ALUSrcB    = ctrl_g.alu_src_b;
  assign ALUOp      = ctrl_g.alu_op;
  assign PCSrc      = ctrl_g.pc_src;
  assign PCEn       = ctrl_g.pc_write | (ctrl_g.branch & zero);
  assign illegal_op = illegal_q;
  assign state_o    = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: instruction-level expected traces vs observed outputs.
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Instruction;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       illegal_op;
  logic [3:0] state_o;

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .Instruction(Instruction), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCEn(PCEn),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct { state_e st; logic mr; } step_t;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     wr_commits = 0;
  logic   pend_ill;
  step_t  trace[$];
  state_e obs_st[$];
  logic   obs_rw[$];
  logic   obs_pcen[$];

  // Memory writes that actually complete (request and ready on the same edge)
  always @(posedge clk) if (MemWrite && mem_ready) wr_commits++;

  function automatic logic legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h08) || (op == 6'h23) ||
           (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
  endfunction

  // Expected controls straight from the per-state table
  function automatic logic [15:0] exp_ctrl(input state_e st, input logic mr, input logic z,
                                           input logic [5:0] op);
    logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, br;
    logic [1:0] srcb, aop, psrc;
    {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, br} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      S_FETCH:  begin mrd = 1'b1; srcb = 2'b01; aop = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: begin srcb = 2'b11; aop = 2'b01; end
      S_MEMADR: begin srca = 1'b1; srcb = 2'b10; aop = 2'b01; end
      S_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin m2r = 1'b1; rw = 1'b1; end
      S_MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
      S_RTEXEC: begin srca = 1'b1; srcb = 2'b00; aop = 2'b00; end
      S_ADDIEX: begin srca = 1'b1; srcb = 2'b10; aop = 2'b01; end
      S_ALUWB:  begin rw = 1'b1; rdst = (op == 6'h00); end
      S_BRANCH: begin srca = 1'b1; aop = 2'b10; psrc = 2'b01; br = 1'b1; end
      S_JUMP:   begin psrc = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, pcw | (br & z), srcb, aop, psrc};
  endfunction

  task automatic push_one(input state_e st);
    step_t s;
    s.st = st; s.mr = 1'($urandom);
    trace.push_back(s);
  endtask

  // A wait state: 'waits' cycles of not-ready, then the ready cycle
  task automatic push_wait(input state_e st, input int waits);
    step_t s;
    s.st = st;
    for (int i = 0; i <= waits; i++) begin
      s.mr = (i == waits);
      trace.push_back(s);
    end
  endtask

  // Expected state sequence of one instruction
  task automatic build_instr(input logic [5:0] op, input int fw, input int mw);
    trace.delete();
    push_wait(S_FETCH, fw);
    push_one(S_DECODE);
    case (op)
      6'h23: begin push_one(S_MEMADR); push_wait(S_MEMRD, mw); push_one(S_MEMWB); end
      6'h2B: begin push_one(S_MEMADR); push_wait(S_MEMWR, mw); end
      6'h00: begin push_one(S_RTEXEC); push_one(S_ALUWB); end
      6'h08: begin push_one(S_ADDIEX); push_one(S_ALUWB); end
      6'h04: push_one(S_BRANCH);
      6'h02: push_one(S_JUMP);
      default: ;
    endcase
  endtask

  // Play a trace starting at a falling edge; zmode 0/1 fixes zero, 2 randomizes it
  task automatic run_trace(input logic [5:0] op, input int zmode);
    logic [15:0] exp_v, act_v;
    logic z;
    obs_st.delete(); obs_rw.delete(); obs_pcen.delete();
    foreach (trace[i]) begin
      z = (zmode == 2) ? 1'($urandom) : (zmode == 1);
      mem_ready   = trace[i].mr;
      zero        = z;
      Instruction = (trace[i].st == S_DECODE) ? op : 6'($urandom);
      #1;
      act_v = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
               ALUSrcA, PCEn, ALUSrcB, ALUOp, PCSrc};
      exp_v = exp_ctrl(trace[i].st, trace[i].mr, z, op);
      n_cmp++;
      if (state_o !== 4'(trace[i].st)) begin
        n_bad++;
        $display("FAIL state op=%h step%0d: got %0d want %0d (%s)", op, i, state_o,
                 4'(trace[i].st), trace[i].st.name());
      end
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL ctrl op=%h step%0d %s: got %h want %h", op, i, trace[i].st.name(),
                 act_v, exp_v);
      end
      n_cmp++;
      if (illegal_op !== pend_ill) begin
        n_bad++;
        $display("FAIL illegal_op op=%h step%0d: got %b want %b", op, i, illegal_op, pend_ill);
      end
      obs_st.push_back(state_e'(state_o));
      obs_rw.push_back(RegWrite);
      obs_pcen.push_back(PCEn);
      pend_ill = (trace[i].st == S_DECODE) && !legal(op);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom); zero = 1'b1; Instruction = 6'($urandom);
      #1;
      n_cmp++;
      if (state_o !== 4'(S_FETCH)) begin
        n_bad++; $display("FAIL reset_state: got %0d want %0d", state_o, 4'(S_FETCH));
      end
      n_cmp++;
      if ({PCWrite, PCEn, IRWrite, RegWrite, MemWrite, MemRead, illegal_op} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_enables: got %b want 0000000",
                 {PCWrite, PCEn, IRWrite, RegWrite, MemWrite, MemRead, illegal_op});
      end
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    pend_ill = 1'b0;
  endtask

  task automatic test_addi();
    logic [3:0] rw_pat;
    build_instr(6'h08, 0, 0);
    run_trace(6'h08, 2);
    n_cmp++;
    if (obs_st.size() != 4 || obs_st[3] != S_ALUWB) begin
      n_bad++; $display("FAIL addi_len: got %0d cycles want 4 ending in ALUWB", obs_st.size());
    end
    rw_pat = '0;
    foreach (obs_rw[i]) if (i < 4) rw_pat[3-i] = obs_rw[i];
    n_cmp++;
    if (rw_pat !== 4'b0001) begin
      n_bad++; $display("FAIL addi_regwrite: got %b want 0001", rw_pat);
    end
  endtask

  task automatic test_lw_wait();
    int n_rd;
    build_instr(6'h23, 0, 3);
    run_trace(6'h23, 2);
    n_rd = 0;
    foreach (obs_st[i]) if (obs_st[i] == S_MEMRD) n_rd++;
    n_cmp++;
    if (n_rd != 4 || obs_st[obs_st.size()-1] != S_MEMWB) begin
      n_bad++; $display("FAIL lw_hold: got %0d MEMRD cycles want 4 then MEMWB", n_rd);
    end
  endtask

  task automatic test_beq();
    build_instr(6'h04, 1, 0);
    run_trace(6'h04, 1);
    n_cmp++;
    if (obs_pcen[obs_pcen.size()-1] !== 1'b1) begin
      n_bad++; $display("FAIL beq_taken_pcen: got %b want 1", obs_pcen[obs_pcen.size()-1]);
    end
    build_instr(6'h04, 0, 0);
    run_trace(6'h04, 0);
    n_cmp++;
    if (obs_pcen[obs_pcen.size()-1] !== 1'b0) begin
      n_bad++; $display("FAIL beq_untaken_pcen: got %b want 0", obs_pcen[obs_pcen.size()-1]);
    end
  endtask

  task automatic test_jmp();
    build_instr(6'h02, 0, 0);
    run_trace(6'h02, 2);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (obs_st[obs_st.size()-1] != S_JUMP || state_o !== 4'(S_FETCH)) begin
      n_bad++; $display("FAIL jmp_return: got state %0d want %0d after JUMP", state_o, 4'(S_FETCH));
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    build_instr(6'h3F, 0, 0);
    run_trace(6'h3F, 2);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (illegal_op !== 1'b1 || state_o !== 4'(S_FETCH)) begin
      n_bad++; $display("FAIL illegal_pulse: got ill=%b state=%0d want 1/%0d", illegal_op, state_o,
                        4'(S_FETCH));
    end
    n_cmp++;
    if ({PCWrite, PCEn, IRWrite, RegWrite, MemWrite} !== 5'b0) begin
      n_bad++; $display("FAIL illegal_writes: got %b want 00000",
                        {PCWrite, PCEn, IRWrite, RegWrite, MemWrite});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (illegal_op !== 1'b0) begin
      n_bad++; $display("FAIL illegal_width: got %b want 0 on second cycle", illegal_op);
    end
    pend_ill = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] op;
    int k;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 6);
      if (k < 6) op = ops[k];
      else begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
      build_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      run_trace(op, 2);
    end
  endtask

  task automatic test_reset_in_memwr();
    int commits0;
    step_t s;
    trace.delete();
    push_wait(S_FETCH, 0);
    push_one(S_DECODE);
    push_one(S_MEMADR);
    s.st = S_MEMWR; s.mr = 1'b0;
    trace.push_back(s);
    trace.push_back(s);
    run_trace(6'h2B, 2);
    commits0 = wr_commits;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'(S_MEMWR) || MemWrite !== 1'b1) begin
      n_bad++; $display("FAIL memwr_pre: got state=%0d MemWrite=%b want %0d/1", state_o, MemWrite,
                        4'(S_MEMWR));
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (MemWrite !== 1'b0 || state_o !== 4'(S_FETCH)) begin
      n_bad++; $display("FAIL memwr_abort: got MemWrite=%b state=%0d want 0/%0d", MemWrite, state_o,
                        4'(S_FETCH));
    end
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (MemWrite !== 1'b0 || MemRead !== 1'b0 || wr_commits != commits0) begin
      n_bad++; $display("FAIL memwr_nowrite: got MemWrite=%b commits=%0d want 0/%0d", MemWrite,
                        wr_commits, commits0);
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0; pend_ill = 1'b0;
    build_instr(6'h00, 1, 0);
    run_trace(6'h00, 2);
  endtask

  initial begin
    rst = 1'b0; mem_ready = 1'b0; zero = 1'b0; Instruction = 6'h00; pend_ill = 1'b0;
    test_reset();
    test_addi();
    test_lw_wait();
    test_beq();
    test_jmp();
    test_illegal();
    test_random();
    test_reset_in_memwr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

endmodule
